// File: rtl/axi4_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi4_arb_pkg
// Shared types and constants for the AXI4 read/write channel arbiters.
//   ar_chan_t   : AR payload {addr, len, size}
//   r_chan_t    : R payload  {data, resp, last}
//   arb_state_e : arbiter FSM states IDLE / ADDR / DATA
// ---------------------------------------------------------------------------
package axi4_arb_pkg;

  localparam int AXI_ADDR_W = 16;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
  } ar_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_chan_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Scans last+1, last+2, ... (mod N)
// and returns the first requester both one-hot and as a binary index.
//   req     : request vector
//   last    : index of the most recently served requester
//   gnt_oh  : one-hot winner (all zero when no request)
//   gnt_idx : binary winner index (0 when no request)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt_oh,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] idx;
  logic         found;

  // NOTE: every output of a combinational block gets a default at the top,
  // so no path through the block can leave a value unassigned (no latch).
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    // k = N wraps back to 'last' itself, so it wins only when it is alone.
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_rd_arbiter
// Shares the AR/R channels of one ID-less AXI4 slave among NUM_M read
// masters. Round-robin grant per burst; the grant is held from the AR
// handshake until the RLAST beat is accepted. AW/W/B are not handled here.
//
// Ports:
//   ACLK, ARESETn          clock, synchronous active-low reset
//   m_ar/m_arvalid/m_arready   per-master AR channel
//   m_r/m_rvalid/m_rready      R channel; payload broadcast, valid per master
//   s_ar/s_arvalid/s_arready   AR channel to the slave
//   s_r/s_rvalid/s_rready      R channel from the slave
//   grant_idx              currently/last granted master
//   busy                   high in ADDR or DATA
//
// Build option:
//   AXI4_RD_ARB_BTB_EN  when defined, re-arbitrate on the RLAST handshake and
//                       go straight to ADDR (no idle cycle between bursts).
// ---------------------------------------------------------------------------
module axi4_rd_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  localparam int GW = $clog2(NUM_M)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  ar_chan_t [NUM_M-1:0]  m_ar,
  input  logic     [NUM_M-1:0]  m_arvalid,
  output logic     [NUM_M-1:0]  m_arready,
  output r_chan_t               m_r,
  output logic     [NUM_M-1:0]  m_rvalid,
  input  logic     [NUM_M-1:0]  m_rready,
  output ar_chan_t              s_ar,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  r_chan_t               s_r,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic     [GW-1:0]     grant_idx,
  output logic                  busy
);

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q,  last_d;
  logic [GW-1:0]     arb_last;
  logic [NUM_M-1:0]  pick_oh;
  logic [GW-1:0]     pick_idx;

`ifdef AXI4_RD_ARB_BTB_EN
  // During DATA the finishing master is the reference point, so the pick
  // made on its RLAST beat naturally skips it unless it is the only one.
  assign arb_last = (state_q == ST_DATA) ? grant_q : last_q;
`else
  assign arb_last = last_q;
`endif

  rr_arbiter #(.N(NUM_M)) u_rr (
    .req     (m_arvalid),
    .last    (arb_last),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    m_arready = '0;
    m_rvalid  = '0;
    m_r       = '0;
    s_ar      = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|pick_oh) begin
          grant_d = pick_idx;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        // A master dropping ARVALID here simply stalls; the grant is kept.
        s_ar               = m_ar[grant_q];
        s_arvalid          = m_arvalid[grant_q];
        m_arready[grant_q] = s_arready;
        if (m_arvalid[grant_q] && s_arready) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        m_r               = s_r;
        m_rvalid[grant_q] = s_rvalid;
        s_rready          = m_rready[grant_q];
        if (s_rvalid && m_rready[grant_q] && s_r.last) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
`ifdef AXI4_RD_ARB_BTB_EN
          if (|pick_oh) begin
            grant_d = pick_idx;
            state_d = ST_ADDR;
          end
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_M - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_rd_arbiter
// Directed bench for axi4_rd_arbiter (NUM_M=2). The bench plays both masters
// and the slave; all expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_axi4_rd_arbiter;
  import axi4_arb_pkg::*;

  localparam int NUM_M = 2;

  logic             ACLK = 1'b0;
  logic             ARESETn;
  ar_chan_t [1:0]   m_ar;
  logic     [1:0]   m_arvalid;
  logic     [1:0]   m_arready;
  r_chan_t          m_r;
  logic     [1:0]   m_rvalid;
  logic     [1:0]   m_rready;
  ar_chan_t         s_ar;
  logic             s_arvalid;
  logic             s_arready;
  r_chan_t          s_r;
  logic             s_rvalid;
  logic             s_rready;
  logic             grant_idx;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  axi4_rd_arbiter #(.NUM_M(NUM_M)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .m_ar      (m_ar),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_r       (m_r),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .s_ar      (s_ar),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_r       (s_r),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESETn   = 1'b0;
    m_arvalid = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_r       = '0;
    cyc();
    cyc();
    ARESETn = 1'b1;
  endtask

  task automatic set_req(input int m, input logic [15:0] addr, input logic [7:0] len);
    m_ar[m].addr = addr;
    m_ar[m].len  = len;
    m_ar[m].size = 3'd2;
    m_arvalid[m] = 1'b1;
  endtask

  // Waits (bounded) for s_arvalid, checks the grant and payload, then
  // completes the AR handshake. Leaves m_arvalid untouched.
  task automatic serve_ar(input int g, input logic [15:0] addr, input logic [7:0] len);
    int n = 0;
    #1;
    while (s_arvalid !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    check("ar_seen", {31'd0, s_arvalid}, 32'd1);
    check("ar_grant", {31'd0, grant_idx}, 32'(g));
    check("ar_busy", {31'd0, busy}, 32'd1);
    check("ar_addr", {16'd0, s_ar.addr}, {16'd0, addr});
    check("ar_len", {24'd0, s_ar.len}, {24'd0, len});
    s_arready = 1'b1;
    #1;
    check("ar_ready", {30'd0, m_arready}, 32'(1 << g));
    cyc();
    s_arready = 1'b0;
  endtask

  // Slave returns len+1 beats; optional 3-cycle master stall at stall_beat.
  task automatic serve_r(input int g, input int len, input logic [31:0] base, input int stall_beat);
    int accepted = 0;
    for (int b = 0; b <= len; b++) begin
      s_rvalid  = 1'b1;
      s_r.data  = base + 32'(b);
      s_r.resp  = b[0] ? RESP_SLVERR : RESP_OKAY;
      s_r.last  = (b == len);
      if (b == stall_beat) begin
        for (int s = 0; s < 3; s++) begin
          m_rready[g] = 1'b0;
          #1;
          check("stall_sready", {31'd0, s_rready}, 32'd0);
          check("stall_valid", {30'd0, m_rvalid}, 32'(1 << g));
          check("stall_data", m_r.data, base + 32'(b));
          cyc();
        end
        m_rready[g] = 1'b1;
      end
      #1;
      check("r_valid", {30'd0, m_rvalid}, 32'(1 << g));
      check("r_data", m_r.data, base + 32'(b));
      check("r_resp", {30'd0, m_r.resp}, b[0] ? 32'h2 : 32'h0);
      check("r_last", {31'd0, m_r.last}, (b == len) ? 32'd1 : 32'd0);
      check("r_sready", {31'd0, s_rready}, 32'd1);
      if (s_rvalid && s_rready) accepted++;
      cyc();
    end
    s_rvalid = 1'b0;
    s_r      = '0;
    check("r_beats", 32'(accepted), 32'(len + 1));
  endtask

  initial begin
    int gap;
    m_ar      = '0;
    m_rready  = 2'b11;
    do_reset();

    // Reset state.
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {31'd0, grant_idx}, 32'd0);
    check("rst_sarvalid", {31'd0, s_arvalid}, 32'd0);
    check("rst_arready", {30'd0, m_arready}, 32'd0);
    check("rst_rvalid", {30'd0, m_rvalid}, 32'd0);
    check("rst_srready", {31'd0, s_rready}, 32'd0);

    // 1: master 0 alone, addr 0x0010, len 3.
    set_req(0, 16'h0010, 8'd3);
    #1;
    check("t1_arb_cycle", {31'd0, s_arvalid}, 32'd0);
    cyc();
    check("t1_arvalid_rise", {31'd0, s_arvalid}, 32'd1);
    serve_ar(0, 16'h0010, 8'd3);
    m_arvalid[0] = 1'b0;
    #1;
    check("t1_data_noar", {31'd0, s_arvalid}, 32'd0);
    serve_r(0, 3, 32'hA000, -1);
    check("t1_busy_fall", {31'd0, busy}, 32'd0);
    check("t1_grant_hold", {31'd0, grant_idx}, 32'd0);

    // 2: both request on the first cycle after reset; m0 then m1.
    do_reset();
    set_req(0, 16'h0100, 8'd0);
    set_req(1, 16'h0200, 8'd0);
    serve_ar(0, 16'h0100, 8'd0);
    m_arvalid[0] = 1'b0;
    serve_r(0, 0, 32'hB000, -1);
    serve_ar(1, 16'h0200, 8'd0);
    m_arvalid[1] = 1'b0;
    serve_r(1, 0, 32'hB100, -1);
    check("t2_idle", {31'd0, busy}, 32'd0);

    // 3: both request continuously, len 1, four bursts: 0,1,0,1.
    set_req(0, 16'h0300, 8'd1);
    set_req(1, 16'h0400, 8'd1);
    for (int i = 0; i < 4; i++) begin
      serve_ar(i % 2, (i % 2 == 0) ? 16'h0300 : 16'h0400, 8'd1);
      serve_r(i % 2, 1, 32'hC000 + 32'(i * 16), -1);
    end
    m_arvalid = '0;
    cyc();

    // 4: m1, len 5, master stalls 3 cycles at beat 2.
    set_req(1, 16'h0500, 8'd5);
    serve_ar(1, 16'h0500, 8'd5);
    m_arvalid[1] = 1'b0;
    serve_r(1, 5, 32'hD000, 1);

    // 5: reset during beat 3 of a len-7 burst from m1.
    set_req(1, 16'h0600, 8'd7);
    serve_ar(1, 16'h0600, 8'd7);
    m_arvalid[1] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      s_rvalid = 1'b1;
      s_r.data = 32'hE000 + 32'(b);
      s_r.resp = RESP_OKAY;
      s_r.last = 1'b0;
      #1;
      check("t5_beat_valid", {30'd0, m_rvalid}, 32'h2);
      if (b == 2) ARESETn = 1'b0;
      cyc();
    end
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_grant", {31'd0, grant_idx}, 32'd0);
    check("t5_rst_rvalid", {30'd0, m_rvalid}, 32'd0);
    check("t5_rst_srready", {31'd0, s_rready}, 32'd0);
    check("t5_rst_arvalid", {31'd0, s_arvalid}, 32'd0);
    check("t5_rst_arready", {30'd0, m_arready}, 32'd0);
    ARESETn = 1'b1;
    #1;
    check("t5_orphan_ignored", {31'd0, s_rready}, 32'd0);
    s_rvalid = 1'b0;
    s_r      = '0;
    set_req(1, 16'h0700, 8'd0);
    serve_ar(1, 16'h0700, 8'd0);
    m_arvalid[1] = 1'b0;
    serve_r(1, 0, 32'hE100, -1);
    check("t5_done", {31'd0, busy}, 32'd0);

    // 6: m1 queued behind m0; idle gap after m0's RLAST handshake.
    set_req(0, 16'h0800, 8'd1);
    serve_ar(0, 16'h0800, 8'd1);
    m_arvalid[0] = 1'b0;
    set_req(1, 16'h0900, 8'd0);
    serve_r(0, 1, 32'hF000, -1);
    gap = 0;
    while (s_arvalid !== 1'b1 && gap < 10) begin
      cyc();
      gap++;
    end
`ifdef AXI4_RD_ARB_BTB_EN
    check("t6_gap", 32'(gap), 32'd0);
`else
    check("t6_gap", 32'(gap), 32'd1);
`endif
    check("t6_grant", {31'd0, grant_idx}, 32'd1);
    serve_ar(1, 16'h0900, 8'd0);
    m_arvalid[1] = 1'b0;
    serve_r(1, 0, 32'hF100, -1);
    check("t6_done", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
